// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared types and constants for the note event arbiter
package note_pkg;
    localparam int NUM_VOICES = 5;
    localparam int DUR_WIDTH  = 32;

    typedef logic [7:0]           note_t;
    typedef logic [DUR_WIDTH-1:0] dur_t;

    typedef struct packed {
        note_t      note;
        dur_t       dur;
        logic [2:0] voice;
        logic       tie;
    } note_event_t;

    // Tracker duration counters wrap to 0 after reaching this value
    localparam dur_t MAX_DURATION = dur_t'(159_999_999);
endpackage

// File: rtl/note_event_arbiter_rr_arbiter.sv
// rtl/note_event_arbiter_rr_arbiter.sv - combinational round-robin grant over voice slots
module rr_arbiter #(
    parameter int N = note_pkg::NUM_VOICES
) (
    input  logic [N-1:0] req_i,
    input  logic [2:0]   ptr_i,
    output logic [N-1:0] grant_oh_o,
    output logic [2:0]   grant_idx_o,
    output logic         any_grant_o
);
    logic       hi_found;
    logic       lo_found;
    logic [2:0] hi_idx;
    logic [2:0] lo_idx;

    // Lowest request at or above the pointer wins; otherwise wrap to the lowest below it
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
                if (i >= int'(ptr_i)) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = 3'(i);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = 3'(i);
                end
            end
        end
        any_grant_o = hi_found || lo_found;
        grant_idx_o = hi_found ? hi_idx : lo_idx;
        grant_oh_o  = '0;
        if (any_grant_o) grant_oh_o[grant_idx_o] = 1'b1;
    end
endmodule

// File: rtl/note_event_arbiter.sv
// rtl/note_event_arbiter.sv - captures per-voice end/tie note events and round-robins them onto one stream
// Optional capture timestamp on timestamp_out when NOTE_ARB_TIMESTAMP_EN is defined.
module note_event_arbiter
    import note_pkg::*;
#(
    parameter int NUM_VOICES = note_pkg::NUM_VOICES,
    parameter int DUR_WIDTH  = note_pkg::DUR_WIDTH,
    parameter int OVF_WIDTH  = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [7:0]            notes_in     [NUM_VOICES-1:0],
    input  logic [DUR_WIDTH-1:0]  durations_in [NUM_VOICES-1:0],
    input  logic                  ready_in,
    output logic                  valid_out,
    output logic [7:0]            note_out,
    output logic [DUR_WIDTH-1:0]  duration_out,
    output logic [2:0]            voice_out,
    output logic                  tie_out,
    output logic [NUM_VOICES-1:0] pending_out,
    output logic [OVF_WIDTH-1:0]  overflow_count_out
`ifdef NOTE_ARB_TIMESTAMP_EN
    ,
    output logic [DUR_WIDTH-1:0]  timestamp_out
`endif
);
    note_t                 prev_note_q [NUM_VOICES-1:0];
    dur_t                  prev_dur_q  [NUM_VOICES-1:0];
    note_event_t           slot_q      [NUM_VOICES-1:0];
    note_event_t           slot_d      [NUM_VOICES-1:0];
    logic [NUM_VOICES-1:0] pend_q, pend_d;
    logic [NUM_VOICES-1:0] ev_end, ev_tie;
    note_event_t           out_q, out_d;
    logic                  valid_q, valid_d;
    logic [2:0]            ptr_q, ptr_d;
    logic [OVF_WIDTH-1:0]  ovf_q, ovf_d;

    logic [NUM_VOICES-1:0] grant_oh;
    logic [2:0]            grant_idx;
    logic                  any_grant;
    logic                  out_load;

`ifdef NOTE_ARB_TIMESTAMP_EN
    dur_t ts_cnt_q;
    dur_t slot_ts_q [NUM_VOICES-1:0];
    dur_t slot_ts_d [NUM_VOICES-1:0];
    dur_t out_ts_q, out_ts_d;
`endif

    rr_arbiter #(.N(NUM_VOICES)) u_rr (
        .req_i       (pend_q),
        .ptr_i       (ptr_q),
        .grant_oh_o  (grant_oh),
        .grant_idx_o (grant_idx),
        .any_grant_o (any_grant)
    );

    always_comb begin
        ev_end = '0;
        ev_tie = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (prev_note_q[i] != 8'd0) begin
                if (notes_in[i] != prev_note_q[i])
                    ev_end[i] = 1'b1;
                else if (durations_in[i] == '0 && prev_dur_q[i] != '0)
                    ev_tie[i] = 1'b1;
            end
        end
    end

    assign out_load = !valid_q || ready_in;

    always_comb begin
        pend_d  = pend_q;
        slot_d  = slot_q;
        out_d   = out_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
`ifdef NOTE_ARB_TIMESTAMP_EN
        slot_ts_d = slot_ts_q;
        out_ts_d  = out_ts_q;
`endif
        if (out_load) begin
            valid_d = any_grant;
            if (any_grant) begin
                out_d = slot_q[grant_idx];
`ifdef NOTE_ARB_TIMESTAMP_EN
                out_ts_d = slot_ts_q[grant_idx];
`endif
                pend_d = pend_q & ~grant_oh;
                ptr_d  = (grant_idx == 3'(NUM_VOICES - 1)) ? 3'd0 : grant_idx + 3'd1;
            end
        end
        // A slot freed by this edge's grant may accept a new event at the same edge
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (ev_end[i] || ev_tie[i]) begin
                if (!pend_d[i]) begin
                    pend_d[i] = 1'b1;
                    slot_d[i] = '{note: prev_note_q[i], dur: prev_dur_q[i],
                                  voice: 3'(i), tie: ev_tie[i]};
`ifdef NOTE_ARB_TIMESTAMP_EN
                    slot_ts_d[i] = ts_cnt_q;
`endif
                end else if (ovf_d != '1) begin
                    ovf_d = ovf_d + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                prev_note_q[i] <= '0;
                prev_dur_q[i]  <= '0;
                slot_q[i]      <= '0;
            end
            pend_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            ovf_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                prev_note_q[i] <= notes_in[i];
                prev_dur_q[i]  <= durations_in[i];
                slot_q[i]      <= slot_d[i];
            end
            pend_q  <= pend_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef NOTE_ARB_TIMESTAMP_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ts_cnt_q <= '0;
            out_ts_q <= '0;
            for (int i = 0; i < NUM_VOICES; i++) slot_ts_q[i] <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 1'b1;
            out_ts_q <= out_ts_d;
            for (int i = 0; i < NUM_VOICES; i++) slot_ts_q[i] <= slot_ts_d[i];
        end
    end

    assign timestamp_out = out_ts_q;
`endif

    assign valid_out          = valid_q;
    assign note_out           = out_q.note;
    assign duration_out       = out_q.dur;
    assign voice_out          = out_q.voice;
    assign tie_out            = out_q.tie;
    assign pending_out        = pend_q;
    assign overflow_count_out = ovf_q;
endmodule

// File: tb/tb_note_event_arbiter.sv
// tb/tb_note_event_arbiter.sv - directed bench with an event-level reference model for note_event_arbiter
module tb_note_event_arbiter;
    localparam int NV = 5;

    logic        clk;
    logic        rst;
    logic [7:0]  notes [NV-1:0];
    logic [31:0] durs  [NV-1:0];
    logic        ready;
    logic        valid_out;
    logic [7:0]  note_out;
    logic [31:0] duration_out;
    logic [2:0]  voice_out;
    logic        tie_out;
    logic [4:0]  pending_out;
    logic [7:0]  overflow_count_out;
`ifdef NOTE_ARB_TIMESTAMP_EN
    logic [31:0] timestamp_out;
`endif

    int tests  = 0;
    int failed = 0;

    note_event_arbiter dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .notes_in           (notes),
        .durations_in       (durs),
        .ready_in           (ready),
        .valid_out          (valid_out),
        .note_out           (note_out),
        .duration_out       (duration_out),
        .voice_out          (voice_out),
        .tie_out            (tie_out),
        .pending_out        (pending_out),
`ifdef NOTE_ARB_TIMESTAMP_EN
        .timestamp_out      (timestamp_out),
`endif
        .overflow_count_out (overflow_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Event-level model: each voice owns one pending record; grants scan round-robin
    int          m_prev_note [NV];
    logic [31:0] m_prev_dur  [NV];
    logic [4:0]  m_pend;
    int          m_snote [NV];
    logic [31:0] m_sdur  [NV];
    bit          m_stie  [NV];
    bit          m_valid;
    int          m_note, m_voice, m_ptr, m_ovf;
    logic [31:0] m_dur;
    bit          m_tie;

    always @(posedge clk) begin
        int g, drops;
        bit e, t;
        if (rst) begin
            for (int i = 0; i < NV; i++) begin
                m_prev_note[i] = 0;
                m_prev_dur[i]  = 0;
            end
            m_pend = '0; m_valid = 0; m_note = 0; m_dur = 0; m_voice = 0; m_tie = 0;
            m_ptr = 0; m_ovf = 0;
        end else begin
            g = -1;
            if (!m_valid || ready) begin
                for (int k = 0; k < NV; k++)
                    if (g < 0 && m_pend[(m_ptr + k) % NV]) g = (m_ptr + k) % NV;
                if (g >= 0) begin
                    m_valid = 1; m_note = m_snote[g]; m_dur = m_sdur[g];
                    m_voice = g; m_tie = m_stie[g];
                    m_pend[g] = 1'b0;
                    m_ptr = (g + 1) % NV;
                end else begin
                    m_valid = 0;
                end
            end
            drops = 0;
            for (int i = 0; i < NV; i++) begin
                e = (m_prev_note[i] != 0) && (notes[i] != m_prev_note[i]);
                t = (m_prev_note[i] != 0) && (notes[i] == m_prev_note[i]) &&
                    (durs[i] == 0) && (m_prev_dur[i] != 0);
                if (e || t) begin
                    if (!m_pend[i]) begin
                        m_pend[i] = 1'b1;
                        m_snote[i] = m_prev_note[i];
                        m_sdur[i]  = m_prev_dur[i];
                        m_stie[i]  = t;
                    end else begin
                        drops++;
                    end
                end
            end
            m_ovf = (m_ovf + drops > 255) ? 255 : m_ovf + drops;
            for (int i = 0; i < NV; i++) begin
                m_prev_note[i] = notes[i];
                m_prev_dur[i]  = durs[i];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cmp_valid", valid_out, m_valid);
        if (m_valid) begin
            chk("cmp_note", note_out, m_note);
            chk("cmp_dur", duration_out, m_dur);
            chk("cmp_voice", voice_out, m_voice);
            chk("cmp_tie", tie_out, m_tie);
        end
        chk("cmp_pending", pending_out, m_pend);
        chk("cmp_ovf", overflow_count_out, m_ovf);
    end

    initial begin
        rst = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            notes[i] = 8'h00;
            durs[i]  = 32'd0;
        end
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", valid_out, 0);
        chk("rst_note", note_out, 0);
        chk("rst_dur", duration_out, 0);
        chk("rst_voice", voice_out, 0);
        chk("rst_tie", tie_out, 0);
        chk("rst_pending", pending_out, 0);
        chk("rst_ovf", overflow_count_out, 0);

        // Single end event on voice 2
        notes[2] = 8'h3C; durs[2] = 32'd99; tick();
        durs[2] = 32'd100; tick();
        notes[2] = 8'h40; durs[2] = 32'd0; tick();
        chk("t1_valid_early", valid_out, 0);
        chk("t1_pending", pending_out, 5'b00100);
        tick();
        chk("t1_valid", valid_out, 1);
        chk("t1_note", note_out, 8'h3C);
        chk("t1_dur", duration_out, 100);
        chk("t1_voice", voice_out, 2);
        chk("t1_tie", tie_out, 0);
        tick();
        chk("t1_drain", valid_out, 0);

        // Reset to pointer 0, then three voices end together
        notes[2] = 8'h00; rst = 1'b1; tick(); rst = 1'b0;
        notes[0] = 8'h10; durs[0] = 32'd7;
        notes[1] = 8'h11; durs[1] = 32'd8;
        notes[4] = 8'h14; durs[4] = 32'd9;
        tick();
        notes[0] = 8'h00; notes[1] = 8'h00; notes[4] = 8'h00;
        durs[0] = 0; durs[1] = 0; durs[4] = 0;
        tick();
        chk("t2_pending", pending_out, 5'b10011);
        tick();
        chk("t2_voice_a", voice_out, 0);
        chk("t2_note_a", note_out, 8'h10);
        chk("t2_dur_a", duration_out, 7);
        tick();
        chk("t2_voice_b", voice_out, 1);
        chk("t2_note_b", note_out, 8'h11);
        tick();
        chk("t2_voice_c", voice_out, 4);
        chk("t2_dur_c", duration_out, 9);
        tick();
        chk("t2_drain", valid_out, 0);

        // Stall with two more voice 3 ends: one kept, one dropped
        ready = 1'b0;
        notes[3] = 8'h33; durs[3] = 32'd3; tick();
        notes[3] = 8'h34; durs[3] = 32'd0; tick(); tick();
        chk("t3_valid", valid_out, 1);
        chk("t3_note", note_out, 8'h33);
        for (int c = 0; c < 10; c++) begin
            if (c == 0) notes[3] = 8'h35;
            if (c == 1) notes[3] = 8'h36;
            tick();
            chk("t3_hold_valid", valid_out, 1);
            chk("t3_hold_note", note_out, 8'h33);
            chk("t3_hold_dur", duration_out, 3);
            chk("t3_hold_voice", voice_out, 3);
        end
        chk("t3_ovf", overflow_count_out, 1);
        chk("t3_pending", pending_out, 5'b01000);
        ready = 1'b1; tick();
        chk("t3_next_note", note_out, 8'h34);
        chk("t3_next_dur", duration_out, 0);
        chk("t3_next_voice", voice_out, 3);
        tick();
        chk("t3_drain", valid_out, 0);

        // Duration wrap on voice 1 yields a tie record
        notes[1] = 8'h45; durs[1] = 32'd159_999_998; tick();
        durs[1] = 32'd159_999_999; tick();
        durs[1] = 32'd0; tick();
        chk("t4_pending", pending_out, 5'b00010);
        durs[1] = 32'd1; tick();
        chk("t4_valid", valid_out, 1);
        chk("t4_note", note_out, 8'h45);
        chk("t4_dur", duration_out, 159_999_999);
        chk("t4_voice", voice_out, 1);
        chk("t4_tie", tie_out, 1);
        durs[1] = 32'd2; tick();
        chk("t4_no_end_a", valid_out, 0);
        tick();
        chk("t4_no_end_b", valid_out, 0);

        // Empty slot becoming active emits nothing
        notes[0] = 8'h30; durs[0] = 32'd0; tick();
        durs[0] = 32'd1; tick();
        durs[0] = 32'd2; tick();
        chk("t5_valid", valid_out, 0);
        chk("t5_pending", pending_out, 0);

        // Reset with pending records and a stalled output
        ready = 1'b0;
        notes[4] = 8'h60; durs[4] = 32'd1; tick();
        notes[0] = 8'h00; notes[1] = 8'h00; notes[3] = 8'h00; notes[4] = 8'h00;
        tick();
        chk("t6_pending_a", pending_out, 5'b11011);
        tick();
        chk("t6_valid", valid_out, 1);
        chk("t6_voice", voice_out, 3);
        chk("t6_note", note_out, 8'h36);
        chk("t6_pending_b", pending_out, 5'b10011);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_rst_valid", valid_out, 0);
        chk("t6_rst_pending", pending_out, 0);
        chk("t6_rst_ovf", overflow_count_out, 0);
        tick(); tick();
        chk("t6_quiet", valid_out, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
